// File: rtl/sync_fifo_rr_drain_if.sv
// Consumer-side FIFO bundle plus the downstream valid/ready stream of the round-robin drain.
// master = drain controller, slave = FIFOs and downstream sink.
interface sync_fifo_rr_drain_if #(
   parameter int N_SRC      = 4,
   parameter int DATA_WIDTH = 16
);
   localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   logic [N_SRC-1:0]            fifo_r_en;
   logic [N_SRC*DATA_WIDTH-1:0] fifo_data_out;
   logic [N_SRC-1:0]            fifo_empty;
   logic                        m_valid;
   logic                        m_ready;
   logic [DATA_WIDTH-1:0]       m_data;
   logic [SRC_W-1:0]            m_src;
   logic                        busy;

   modport master (
      output fifo_r_en,
      input  fifo_data_out,
      input  fifo_empty,
      output m_valid,
      input  m_ready,
      output m_data,
      output m_src,
      output busy
   );

   modport slave (
      input  fifo_r_en,
      output fifo_data_out,
      output fifo_empty,
      input  m_valid,
      output m_ready,
      input  m_data,
      input  m_src,
      input  busy
   );
endinterface

// File: rtl/sync_fifo_rr_drain.sv
// Round-robin drain of N synchronous FIFOs into a 4-entry buffer feeding a valid/ready stream.
// Optional burst grants per source are enabled with SYNC_FIFO_RR_DRAIN_BURST_EN.
module sync_fifo_rr_drain #(
   parameter int N_SRC      = 4,
   parameter int DATA_WIDTH = 16,
   parameter int BURST_LEN  = 4
) (
   input logic clk,
   input logic rst_n,
   sync_fifo_rr_drain_if.master bus
);
   localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   if (N_SRC < 2 || N_SRC > 16 || BURST_LEN < 1 || BURST_LEN > 16) begin : g_cfg_check
      $error("sync_fifo_rr_drain: N_SRC must be 2..16 and BURST_LEN 1..16");
   end

   logic [SRC_W-1:0]      ptr;
   logic [SRC_W-1:0]      cand;
   logic                  cand_ok;
   logic [SRC_W-1:0]      idx;
   logic                  credit_ok;
   logic                  issue;
   logic [N_SRC-1:0]      r_en;
   logic [SRC_W-1:0]      cand_next;

   logic                  inflight;
   logic [SRC_W-1:0]      tag;
   logic [DATA_WIDTH-1:0] cap_word;

   logic [DATA_WIDTH-1:0] ob_data [4];
   logic [SRC_W-1:0]      ob_src  [4];
   logic [1:0]            wr_ptr;
   logic [1:0]            rd_ptr;
   logic [2:0]            count;
   logic                  pop;

   // Descending scan so the lowest circular offset from ptr wins.
   always_comb begin
      cand    = '0;
      cand_ok = 1'b0;
      idx     = '0;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         idx = SRC_W'((int'(ptr) + k) % N_SRC);
         if (!bus.fifo_empty[idx]) begin
            cand    = idx;
            cand_ok = 1'b1;
         end
      end
   end

   // Credits count buffered words plus the read still in flight; a pop this cycle frees nothing.
   assign credit_ok = (({1'b0, count} + {3'b000, inflight}) < 4'd4);
   assign issue     = rst_n && cand_ok && credit_ok;
   assign cand_next = (cand == SRC_W'(N_SRC - 1)) ? '0 : cand + 1'b1;

   always_comb begin
      r_en = '0;
      if (issue) r_en[cand] = 1'b1;
   end

   assign bus.fifo_r_en = r_en;

`ifdef SYNC_FIFO_RR_DRAIN_BURST_EN
   localparam int BW = $clog2(BURST_LEN + 1);

   logic [BW-1:0] burst_cnt;
   logic [BW-1:0] burst_next;

   // A grant away from ptr starts a fresh burst on the new source.
   always_comb begin
      burst_next = BW'(1);
      if (cand == ptr) burst_next = burst_cnt + BW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr       <= '0;
         burst_cnt <= '0;
      end else if (issue) begin
         if (burst_next >= BW'(BURST_LEN)) begin
            ptr       <= cand_next;
            burst_cnt <= '0;
         end else begin
            ptr       <= cand;
            burst_cnt <= burst_next;
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (issue) begin
         ptr <= cand_next;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inflight <= 1'b0;
         tag      <= '0;
      end else begin
         inflight <= issue;
         if (issue) tag <= cand;
      end
   end

   assign cap_word = bus.fifo_data_out[int'(tag)*DATA_WIDTH +: DATA_WIDTH];
   assign pop      = (count != 3'd0) && bus.m_ready;

   // Output buffer: capture the word returned one cycle after its read, pop on handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int e = 0; e < 4; e++) begin
            ob_data[e] <= '0;
            ob_src[e]  <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (inflight) begin
            ob_data[wr_ptr] <= cap_word;
            ob_src[wr_ptr]  <= tag;
            wr_ptr          <= wr_ptr + 2'd1;
         end
         if (pop) rd_ptr <= rd_ptr + 2'd1;
         case ({inflight, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   assign bus.m_valid = (count != 3'd0);
   assign bus.m_data  = ob_data[rd_ptr];
   assign bus.m_src   = ob_src[rd_ptr];
   assign bus.busy    = (count != 3'd0) || inflight;

endmodule

// File: tb/tb_sync_fifo_rr_drain.sv
// Directed bench for sync_fifo_rr_drain: FIFO models, per-source scoreboard, immediate-assert checks.
module tb_sync_fifo_rr_drain;
   localparam int N  = 4;
   localparam int DW = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int checks   = 0;
   int failures = 0;
   int reads_issued = 0;

   logic [DW-1:0] fifo_q [N][$];
   logic [DW-1:0] sb     [N][$];
   logic [1:0]    popped_src  [$];
   logic [DW-1:0] popped_data [$];

   sync_fifo_rr_drain_if #(.N_SRC(N), .DATA_WIDTH(DW)) bus ();

   sync_fifo_rr_drain #(.N_SRC(N), .DATA_WIDTH(DW), .BURST_LEN(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mk_word(int s, int k);
      return 16'hC000 | 16'(s << 8) | 16'(k);
   endfunction

   task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic update_empty();
      for (int i = 0; i < N; i++) bus.fifo_empty[i] = (fifo_q[i].size() == 0);
   endtask

   // Pushes one word into FIFO src and records it for the per-source scoreboard.
   task automatic applyStimulus(int src, logic [DW-1:0] data);
      fifo_q[src].push_back(data);
      sb[src].push_back(data);
      update_empty();
   endtask

   // One clock: sample pre-edge, pop FIFO models on r_en, score accepted words.
   task automatic tick();
      logic [N-1:0]  ren_s;
      logic [N-1:0]  emp_s;
      logic          pop_s;
      logic [1:0]    src_s;
      logic [DW-1:0] dat_s;
      logic [DW-1:0] exp_d;
      #1;
      ren_s = bus.fifo_r_en;
      emp_s = bus.fifo_empty;
      pop_s = bus.m_valid && bus.m_ready && rst_n;
      src_s = bus.m_src;
      dat_s = bus.m_data;
      checkOutput("ren_legal", 32'(($countones(ren_s) > 1) || ((ren_s & emp_s) != '0)), 32'd0);
      checkOutput("count_le4", 32'(dut.count <= 3'd4), 32'd1);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (ren_s[i] && fifo_q[i].size() > 0) begin
            bus.fifo_data_out[i*DW +: DW] = fifo_q[i].pop_front();
            reads_issued++;
         end
      end
      update_empty();
      if (pop_s) begin
         popped_src.push_back(src_s);
         popped_data.push_back(dat_s);
         checkOutput("sb_nonempty", 32'(sb[src_s].size() > 0), 32'd1);
         if (sb[src_s].size() > 0) begin
            exp_d = sb[src_s].pop_front();
            checkOutput("sb_data", 32'(dat_s), 32'(exp_d));
         end
      end
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      bus.m_ready = 1'b0;
      bus.fifo_data_out = '0;
      for (int i = 0; i < N; i++) begin
         fifo_q[i].delete();
         sb[i].delete();
      end
      update_empty();
      popped_src.delete();
      popped_data.delete();
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      logic [1:0] exp_burst [8];
      int         rd0;
      int         pushed;

      bus.m_ready = 1'b0;
      bus.fifo_data_out = '0;
      bus.fifo_empty = '1;

      // Reset state
      apply_reset();
      checkOutput("rst_m_valid", 32'(bus.m_valid), 32'd0);
      checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("rst_r_en", 32'(bus.fifo_r_en), 32'd0);
      checkOutput("rst_m_data", 32'(bus.m_data), 32'd0);
      checkOutput("rst_m_src", 32'(bus.m_src), 32'd0);

      // Single source: FIFO 2 holds A1, A2
      $display("[TB] single source");
      bus.m_ready = 1'b1;
      applyStimulus(2, 16'h00A1);
      applyStimulus(2, 16'h00A2);
      #1;
      checkOutput("single_ren_c0", 32'(bus.fifo_r_en), 32'h4);
      tick();
      checkOutput("single_ren_c1", 32'(bus.fifo_r_en), 32'h4);
      tick();
      checkOutput("single_valid_c2", 32'(bus.m_valid), 32'd1);
      checkOutput("single_data_c2", 32'(bus.m_data), 32'h00A1);
      checkOutput("single_src_c2", 32'(bus.m_src), 32'd2);
      checkOutput("single_ren_c2", 32'(bus.fifo_r_en), 32'd0);
      tick();
      checkOutput("single_data_c3", 32'(bus.m_data), 32'h00A2);
      checkOutput("single_busy_c3", 32'(bus.busy), 32'd1);
      tick();
      checkOutput("single_valid_c4", 32'(bus.m_valid), 32'd0);
      checkOutput("single_busy_c4", 32'(bus.busy), 32'd0);

      // Fairness: 3 words in every FIFO, full throughput in rotation
      $display("[TB] fairness");
      apply_reset();
      bus.m_ready = 1'b1;
      for (int s = 0; s < N; s++)
         for (int k = 0; k < 3; k++) applyStimulus(s, mk_word(s, k));
      tick();
      tick();
      for (int n = 0; n < 12; n++) begin
         checkOutput("fair_valid", 32'(bus.m_valid), 32'd1);
         checkOutput("fair_src", 32'(bus.m_src), 32'(n % 4));
         checkOutput("fair_data", 32'(bus.m_data), 32'(mk_word(n % 4, n / 4)));
         tick();
      end
      checkOutput("fair_idle", 32'(bus.m_valid), 32'd0);

      // Backpressure: 8 words per FIFO, m_ready low for 10 cycles
      $display("[TB] backpressure");
      apply_reset();
      for (int s = 0; s < N; s++)
         for (int k = 0; k < 8; k++) applyStimulus(s, mk_word(s, k));
      rd0 = reads_issued;
      for (int c = 0; c < 10; c++) tick();
      checkOutput("bp_reads", 32'(reads_issued - rd0), 32'd4);
      checkOutput("bp_valid", 32'(bus.m_valid), 32'd1);
      checkOutput("bp_src", 32'(bus.m_src), 32'd0);
      checkOutput("bp_data", 32'(bus.m_data), 32'(mk_word(0, 0)));
      bus.m_ready = 1'b1;
      for (int c = 0; c < 200 && popped_src.size() < 32; c++) tick();
      checkOutput("bp_drained", 32'(popped_src.size()), 32'd32);
      for (int n = 0; n < 32 && n < popped_src.size(); n++) begin
         checkOutput("bp_order_src", 32'(popped_src[n]), 32'(n % 4));
         checkOutput("bp_order_data", 32'(popped_data[n]), 32'(mk_word(n % 4, n / 4)));
      end

      // Random m_ready with random pushes over 1000 words
      $display("[TB] random backpressure");
      apply_reset();
      pushed = 0;
      for (int c = 0; c < 20000 && popped_src.size() < 1000; c++) begin
         if (pushed < 1000 && $urandom_range(0, 3) != 0) begin
            applyStimulus(int'($urandom_range(0, N - 1)), 16'($urandom()));
            pushed++;
         end
         bus.m_ready = 1'($urandom_range(0, 1));
         tick();
      end
      checkOutput("rand_total", 32'(popped_src.size()), 32'd1000);

      // Burst scenario: FIFO 0 six words, FIFO 1 two words
      $display("[TB] burst pattern");
`ifdef SYNC_FIFO_RR_DRAIN_BURST_EN
      exp_burst = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
`else
      exp_burst = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
      apply_reset();
      bus.m_ready = 1'b1;
      for (int k = 0; k < 6; k++) applyStimulus(0, mk_word(0, k));
      for (int k = 0; k < 2; k++) applyStimulus(1, mk_word(1, k));
      for (int c = 0; c < 50 && popped_src.size() < 8; c++) tick();
      checkOutput("burst_total", 32'(popped_src.size()), 32'd8);
      for (int n = 0; n < 8 && n < popped_src.size(); n++)
         checkOutput("burst_src", 32'(popped_src[n]), 32'(exp_burst[n]));

      // Reset mid-stream with two words buffered and one in flight
      $display("[TB] reset mid-stream");
      apply_reset();
      for (int s = 0; s < N; s++)
         for (int k = 0; k < 4; k++) applyStimulus(s, mk_word(s, k));
      tick();
      tick();
      tick();
      checkOutput("mid_count", 32'(dut.count), 32'd2);
      checkOutput("mid_valid", 32'(bus.m_valid), 32'd1);
      rst_n = 1'b0;
      tick();
      checkOutput("mid_rst_valid", 32'(bus.m_valid), 32'd0);
      checkOutput("mid_rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("mid_rst_ren", 32'(bus.fifo_r_en), 32'd0);
      for (int i = 0; i < N; i++) sb[i] = fifo_q[i];
      rst_n = 1'b1;
      #1;
      checkOutput("mid_restart_ren", 32'(bus.fifo_r_en), 32'h1);
      bus.m_ready = 1'b1;
      tick();
      tick();
      checkOutput("mid_restart_src", 32'(bus.m_src), 32'd0);
      checkOutput("mid_restart_data", 32'(bus.m_data), 32'(mk_word(0, 1)));
      for (int c = 0; c < 100 && bus.busy; c++) tick();
      checkOutput("mid_drain_busy", 32'(bus.busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
